// File: rtl/receptor_referencia.sv
// 8N1 serial receiver feeding a reference register: 16x oversampling, mid-bit
// sampling, one-cycle load strobe on a good frame and error strobe on a bad stop bit.
module receptor_referencia #(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] dato,
    output logic       enviar,
    output logic       error_trama,
    output logic       ocupado
);

    localparam int DIV = CLK_HZ / (BAUD * 16);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(DIV - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
        ESPERA = 3'd4
    } estado_t;

    estado_t       estado;
    logic          rx_m, rx_s;
    logic [DW-1:0] div_cnt;
    logic          tick;
    logic [3:0]    tick_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;

    // Line idles high, so the synchronizer resets to 1 to avoid a false start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            div_cnt <= '0;
        else if (div_cnt == DIV_MAX)
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + 1'b1;
    end

    assign tick = (div_cnt == DIV_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado      <= IDLE;
            tick_cnt    <= 4'd0;
            bit_idx     <= 3'd0;
            shreg       <= 8'h00;
            dato        <= 8'h00;
            enviar      <= 1'b0;
            error_trama <= 1'b0;
        end else begin
            enviar      <= 1'b0;
            error_trama <= 1'b0;
            case (estado)
                IDLE: begin
                    tick_cnt <= 4'd0;
                    bit_idx  <= 3'd0;
                    if (!rx_s)
                        estado <= START;
                end
                // Eight ticks in is the middle of the start bit; a high line there is a glitch.
                START: begin
                    if (tick) begin
                        if (tick_cnt == 4'd7) begin
                            tick_cnt <= 4'd0;
                            estado   <= rx_s ? IDLE : DATA;
                        end else begin
                            tick_cnt <= tick_cnt + 4'd1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        tick_cnt <= tick_cnt + 4'd1;
                        if (tick_cnt == 4'd15) begin
                            shreg[bit_idx] <= rx_s;
                            bit_idx        <= bit_idx + 3'd1;
                            if (bit_idx == 3'd7)
                                estado <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        tick_cnt <= tick_cnt + 4'd1;
                        if (tick_cnt == 4'd15) begin
                            if (rx_s) begin
                                dato   <= shreg;
                                enviar <= 1'b1;
                                estado <= IDLE;
                            end else begin
                                error_trama <= 1'b1;
                                estado      <= ESPERA;
                            end
                        end
                    end
                end
                // After a bad stop bit the line must return high before the next frame.
                ESPERA: begin
                    if (rx_s)
                        estado <= IDLE;
                end
                default: estado <= IDLE;
            endcase
        end
    end

    assign ocupado = (estado != IDLE);

endmodule

// File: tb/tb_receptor_referencia.sv
// Bench for receptor_referencia: drives 8N1 frames on rx and checks the
// delivered bytes and error strobes against the frames it sent.
module tb_receptor_referencia;

    localparam int CLK_HZ = 1_600_000;
    localparam int BAUD   = 10_000;
    localparam int BIT    = 160;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] dato;
    logic       enviar;
    logic       error_trama;
    logic       ocupado;

    int checks = 0;
    int errors = 0;

    int         n_env  = 0;
    int         n_err  = 0;
    int         n_viol = 0;
    logic [7:0] got_q[$];
    logic [7:0] prev_dato = 8'h00;
    logic       prev_env  = 1'b0;
    logic       prev_err  = 1'b0;

    receptor_referencia #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .dato       (dato),
        .enviar     (enviar),
        .error_trama(error_trama),
        .ocupado    (ocupado)
    );

    always #5 clk = ~clk;

    // Strobe/data monitor: collects delivered bytes and counts rule breaks
    // (overlapping strobes, strobes wider than a cycle, dato moving without enviar).
    always @(negedge clk) begin
        if (rst) begin
            prev_dato <= dato;
            prev_env  <= 1'b0;
            prev_err  <= 1'b0;
        end else begin
            if (enviar) begin
                n_env <= n_env + 1;
                got_q.push_back(dato);
            end
            if (error_trama) n_err <= n_err + 1;
            if ((enviar && error_trama) || (enviar && prev_env) ||
                (error_trama && prev_err) || (dato !== prev_dato && !enviar))
                n_viol <= n_viol + 1;
            prev_dato <= dato;
            prev_env  <= enviar;
            prev_err  <= error_trama;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stopb, input int bc);
        rx = 1'b0;
        repeat (bc) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (bc) @(negedge clk);
        end
        rx = stopb;
        repeat (bc) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (dato !== 8'h00) begin errors++; $display("FAIL reset_dato got %h want 00", dato); end
        checks++; if (enviar !== 1'b0) begin errors++; $display("FAIL reset_enviar got %b want 0", enviar); end
        checks++; if (error_trama !== 1'b0) begin errors++; $display("FAIL reset_error got %b want 0", error_trama); end
        checks++; if (ocupado !== 1'b0) begin errors++; $display("FAIL reset_ocupado got %b want 0", ocupado); end
        rst = 1'b0;
        idle(50);
        checks++; if (ocupado !== 1'b0) begin errors++; $display("FAIL idle_ocupado got %b want 0", ocupado); end
    endtask

    task automatic test_frame_ok();
        int e0, r0;
        e0 = n_env; r0 = n_err;
        send_frame(8'hA5, 1'b1, BIT);
        idle(40);
        checks++; if (n_env - e0 !== 1) begin errors++; $display("FAIL a5_enviar_count got %0d want 1", n_env - e0); end
        checks++; if (dato !== 8'hA5) begin errors++; $display("FAIL a5_dato got %h want a5", dato); end
        checks++; if (n_err !== r0) begin errors++; $display("FAIL a5_error_count got %0d want %0d", n_err, r0); end
        checks++; if (ocupado !== 1'b0) begin errors++; $display("FAIL a5_ocupado got %b want 0", ocupado); end
    endtask

    task automatic test_glitch();
        int e0, r0;
        logic [7:0] d0;
        e0 = n_env; r0 = n_err; d0 = dato;
        rx = 1'b0;
        repeat (20) @(negedge clk);
        checks++; if (ocupado !== 1'b1) begin errors++; $display("FAIL glitch_busy got %b want 1", ocupado); end
        repeat (20) @(negedge clk);
        idle(150);
        checks++; if (n_env !== e0) begin errors++; $display("FAIL glitch_enviar got %0d want %0d", n_env, e0); end
        checks++; if (n_err !== r0) begin errors++; $display("FAIL glitch_error got %0d want %0d", n_err, r0); end
        checks++; if (dato !== d0) begin errors++; $display("FAIL glitch_dato got %h want %h", dato, d0); end
        checks++; if (ocupado !== 1'b0) begin errors++; $display("FAIL glitch_idle got %b want 0", ocupado); end
    endtask

    task automatic test_frame_error();
        int e0, r0;
        logic [7:0] d0;
        e0 = n_env; r0 = n_err; d0 = dato;
        send_frame(8'h3C, 1'b0, BIT);
        idle(BIT);
        checks++; if (n_err - r0 !== 1) begin errors++; $display("FAIL ferr_error_count got %0d want 1", n_err - r0); end
        checks++; if (n_env !== e0) begin errors++; $display("FAIL ferr_enviar got %0d want %0d", n_env, e0); end
        checks++; if (dato !== d0) begin errors++; $display("FAIL ferr_dato got %h want %h", dato, d0); end
        checks++; if (ocupado !== 1'b0) begin errors++; $display("FAIL ferr_ocupado got %b want 0", ocupado); end
        send_frame(8'h81, 1'b1, BIT);
        idle(40);
        checks++; if (dato !== 8'h81) begin errors++; $display("FAIL ferr_next_dato got %h want 81", dato); end
        checks++; if (n_env - e0 !== 1) begin errors++; $display("FAIL ferr_next_enviar got %0d want 1", n_env - e0); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_q[$];
        exp_q = '{8'h00, 8'hFF, 8'h5A};
        got_q.delete();
        foreach (exp_q[i]) send_frame(exp_q[i], 1'b1, BIT);
        idle(40);
        checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL b2b_count got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_byte%0d got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_midframe();
        int e0, r0;
        logic [7:0] b;
        b = 8'h77;
        e0 = n_env; r0 = n_err;
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            repeat (BIT) @(negedge clk);
        end
        rx = b[4];
        repeat (80) @(negedge clk);
        #3 rst = 1'b1;
        #1;
        checks++; if (dato !== 8'h00) begin errors++; $display("FAIL rstmid_dato got %h want 00", dato); end
        checks++; if (ocupado !== 1'b0) begin errors++; $display("FAIL rstmid_ocupado got %b want 0", ocupado); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle(BIT * 6);
        checks++; if (n_env !== e0) begin errors++; $display("FAIL rstmid_enviar got %0d want %0d", n_env, e0); end
        checks++; if (n_err !== r0) begin errors++; $display("FAIL rstmid_error got %0d want %0d", n_err, r0); end
        checks++; if (dato !== 8'h00) begin errors++; $display("FAIL rstmid_hold got %h want 00", dato); end
        send_frame(8'h12, 1'b1, BIT);
        idle(40);
        checks++; if (dato !== 8'h12) begin errors++; $display("FAIL rstmid_next got %h want 12", dato); end
        checks++; if (n_env - e0 !== 1) begin errors++; $display("FAIL rstmid_next_enviar got %0d want 1", n_env - e0); end
    endtask

    task automatic test_slow_baud();
        int e0, r0;
        e0 = n_env; r0 = n_err;
        send_frame(8'h96, 1'b1, 163);
        idle(40);
        checks++; if (dato !== 8'h96) begin errors++; $display("FAIL slow_dato got %h want 96", dato); end
        checks++; if (n_env - e0 !== 1) begin errors++; $display("FAIL slow_enviar got %0d want 1", n_env - e0); end
        checks++; if (n_err !== r0) begin errors++; $display("FAIL slow_error got %0d want %0d", n_err, r0); end
    endtask

    // Random frames with small rate error and random gaps; good stop bits must
    // deliver the byte in order, bad ones must raise exactly one error each.
    task automatic test_random();
        logic [7:0] exp_q[$];
        logic [7:0] b;
        logic       stopb;
        int         r0, nerr_exp, bc;
        got_q.delete();
        r0 = n_err; nerr_exp = 0;
        for (int k = 0; k < 12; k++) begin
            b     = 8'($urandom);
            stopb = ($urandom_range(0, 3) != 0);
            bc    = $urandom_range(157, 163);
            send_frame(b, stopb, bc);
            if (stopb) exp_q.push_back(b);
            else nerr_exp++;
            idle(stopb ? $urandom_range(0, 40) : $urandom_range(20, 60));
        end
        idle(40);
        checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL rand_count got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_byte%0d got %h want %h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (n_err - r0 !== nerr_exp) begin errors++; $display("FAIL rand_errors got %0d want %0d", n_err - r0, nerr_exp); end
    endtask

    task automatic test_invariants();
        checks++; if (n_viol !== 0) begin errors++; $display("FAIL strobe_rules got %0d violations want 0", n_viol); end
    endtask

    initial begin
        test_reset();
        test_frame_ok();
        test_glitch();
        test_frame_error();
        test_back_to_back();
        test_reset_midframe();
        test_slow_baud();
        test_random();
        test_invariants();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/receptor_referencia.md
RECEPTOR_REFERENCIA -- requirements
Module: receptor_referencia

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000: system clock frequency in Hz.
REQ-002 Parameter BAUD, default 9600: serial bit rate in bit/s.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 rx  input  1  asynchronous serial line, 8N1 framing, idle high, LSB first.
REQ-006 dato  output  8  last correctly framed byte; drives the reference register data input.
REQ-007 enviar  output  1  one-cycle strobe; dato is valid while high; drives the reference register load input.
REQ-008 error_trama  output  1  one-cycle strobe on a framing error (stop bit low).
REQ-009 ocupado  output  1  high whenever the FSM is not in IDLE.

Function
REQ-010 rx SHALL pass through a 2-flop synchronizer (rx_s) before any use; both flops reset to 1.
REQ-011 A tick generator SHALL count 0..DIV-1 with DIV = floor(CLK_HZ/(BAUD*16)) and emit a one-cycle tick at DIV-1, free-running, giving 16 ticks per bit.
REQ-012 FSM states SHALL be IDLE, START, DATA, STOP, ESPERA; reset state IDLE.
REQ-013 IDLE: when rx_s = 0, go to START and clear the 4-bit tick count and 3-bit bit index.
REQ-014 START: on the 8th tick (mid start bit), rx_s = 0 -> DATA with the tick count cleared; rx_s = 1 -> IDLE as a glitch, with no strobe.
REQ-015 DATA: every 16th tick, shift rx_s into bit position [bit index] (LSB first); after bit 7, go to STOP with the tick count cleared.
REQ-016 STOP: on the 16th tick (mid stop bit), rx_s = 1 -> load the assembled byte into dato, pulse enviar, and go to IDLE.
REQ-017 STOP: on the 16th tick, rx_s = 0 -> pulse error_trama, leave dato unchanged, and go to ESPERA.
REQ-018 ESPERA: remain until rx_s = 1, then go to IDLE; a low line SHALL never start a new frame from ESPERA.
REQ-019 enviar and error_trama SHALL each be high for exactly one clk cycle, registered, in the cycle after the deciding stop-bit tick, and SHALL never be high together.
REQ-020 dato SHALL change only in the cycle where enviar rises, and SHALL hold its value otherwise, including through glitches and framing errors.
REQ-021 The FSM SHALL re-arm directly from IDLE, so back-to-back frames with a single stop bit are all received.
REQ-022 The counters SHALL wrap only as specified; no state SHALL stall except ESPERA, which waits on the line.

Reset
REQ-023 While rst = 1, independent of clk: dato = 8'h00, enviar = 0, error_trama = 0, ocupado = 0, FSM = IDLE, all counters = 0, synchronizer flops = 1.
REQ-024 Reset asserted mid-frame SHALL abort the frame with no strobe.
REQ-025 After reset release, reception SHALL begin only at the next falling edge of rx_s.

Verification
Bench parameters: CLK_HZ = 1_600_000, BAUD = 10_000, giving DIV = 10 and 160 clk cycles per bit.
REQ-026 Send 0xA5 with a high stop bit -> one enviar pulse, dato = 8'hA5, error_trama stays 0, ocupado returns to 0.
REQ-027 Drive rx low for 40 cycles, then high -> no strobe, dato unchanged, FSM back in IDLE.
REQ-028 Send 0x3C with the stop bit low, then idle high -> one error_trama pulse, no enviar, dato holds its previous value; the next frame 0x81 gives dato = 8'h81.
REQ-029 Send 0x00, 0xFF and 0x5A back-to-back with no idle gap -> three enviar pulses with dato = 00, FF, 5A in order.
REQ-030 Assert rst during bit 4 of 0x77, release it, then send 0x12 -> no pulse for the aborted frame, dato = 8'h00 until the 0x12 frame completes, then dato = 8'h12.
REQ-031 Send 0x96 with a bit period 2% longer than nominal -> dato = 8'h96 received correctly.
